// File: rtl/tea_ctl_pkg.sv
// rtl/tea_ctl_pkg.sv - shared types, defaults and round-robin pick for tea_arbiter
// Purpose: FSM state enum, default parameter constants and the
//          combinational round-robin selection used by the arbiter.
// Ports:   none (package).
package tea_ctl_pkg;

  localparam int N_DEF       = 4;
  localparam int W_DEF       = 32;
  localparam int SYNC_DEF    = 2;
  localparam int TIMEOUT_DEF = 1024;
  localparam int NMAX        = 16;

  typedef enum logic [1:0] {IDLE, REQ, DROP, RSP} tea_arb_state_t;

  // Equivalent to rotating req by last+1, finding the first one and adding
  // the offset back modulo n. Walks offsets 1..n so the client just served
  // (offset n) has the lowest priority.
  function automatic int rr_pick(input logic [NMAX-1:0] req, input int last, input int n);
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= NMAX; k++) begin
      if (k <= n && !found) begin
        idx = (last + k) % n;
        if (req[idx[3:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tea_arbiter_if.sv
// rtl/tea_arbiter_if.sv - client, core and response signal bundle for tea_arbiter
// Purpose: groups the client request bus, the core req/ack datapath and the
//          response channel.
// Ports:   cl_req/cl_wdata/cl_gnt (clients), eng_req/eng_wdata/eng_ack/
//          eng_rdata (cipher core), rsp_valid/rsp_ready/rsp_id/rsp_data/
//          rsp_err (response), busy (status).
//          master: arbiter side; slave: clients/core/consumer side.
interface tea_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   cl_req;
  logic [N*W-1:0] cl_wdata;
  logic [N-1:0]   cl_gnt;
  logic           eng_req;
  logic [W-1:0]   eng_wdata;
  logic           eng_ack;
  logic [W-1:0]   eng_rdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;

  modport master (
    input  cl_req, cl_wdata, eng_ack, eng_rdata, rsp_ready,
    output cl_gnt, eng_req, eng_wdata, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    output cl_req, cl_wdata, eng_ack, eng_rdata, rsp_ready,
    input  cl_gnt, eng_req, eng_wdata, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/tea_sync.sv
// rtl/tea_sync.sv - multi-flop single-bit synchroniser
// Purpose: brings the asynchronous core ack into the arbiter clock domain.
// Ports:   clk, rst (async active-high, clears to 0), d_i (async input),
//          q_o (synchronised output, SYNC edges behind d_i).
module tea_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC-2:0], d_i};
  end

  assign q_o = sync_q[SYNC-1];

endmodule

// File: rtl/tea_arbiter.sv
// rtl/tea_arbiter.sv - round-robin arbiter/sequencer sharing one TEA core
// Purpose: grants one client at a time, runs a four-phase req/ack exchange
//          with the core and returns the result tagged with the client ID;
//          a watchdog aborts exchanges the core never acknowledges.
// Ports:   clk, rst (async active-high), bus (tea_arbiter_if.master).
module tea_arbiter
  import tea_ctl_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int SYNC    = SYNC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  tea_arbiter_if.master bus
);

  localparam int IDW = $clog2(N);
  localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  tea_arb_state_t state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           req_q, req_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   data_q, data_d;
  logic           err_q, err_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic           ack_s;
  logic [IDW-1:0] pick;
  logic           wd_exp;

  tea_sync #(.SYNC(SYNC)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.eng_ack),
    .q_o (ack_s)
  );

  assign pick   = IDW'(rr_pick(NMAX'(bus.cl_req), int'(last_q), N));
  // TIMEOUT of 0 never expires, so the FSM waits on the core indefinitely.
  assign wd_exp = (TIMEOUT != 0) && (wd_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(N - 1);
      gnt_q   <= '0;
      req_q   <= 1'b0;
      wdata_q <= '0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      wdata_q <= wdata_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = '0;
    req_d   = req_q;
    wdata_d = wdata_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.cl_req) begin
          gnt_d[pick] = 1'b1;
          wdata_d     = bus.cl_wdata[int'(pick)*W +: W];
          id_d        = pick;
          last_d      = pick;
          req_d       = 1'b1;
          wd_d        = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // A real ack wins over a coincident watchdog expiry.
        if (ack_s) begin
          data_d  = bus.eng_rdata;
          err_d   = 1'b0;
          req_d   = 1'b0;
          wd_d    = '0;
          state_d = DROP;
        end else if (wd_exp) begin
          data_d  = '0;
          err_d   = 1'b1;
          req_d   = 1'b0;
          wd_d    = '0;
          state_d = DROP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DROP: begin
        if (!ack_s) begin
          state_d = RSP;
        end else if (wd_exp) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RSP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cl_gnt    = gnt_q;
  assign bus.eng_req   = req_q;
  assign bus.eng_wdata = wdata_q;
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tea_arbiter.sv
// tb/tb_tea_arbiter.sv - self-checking bench for tea_arbiter
module tb_tea_arbiter;

  localparam logic [31:0] KEY = 32'h9e3779b9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tea_arbiter_if #(.N(4), .W(32)) bus ();

  tea_arbiter #(.N(4), .W(32), .SYNC(2), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core model: raises ack core_lat cycles after seeing req, drops it once
  // req is gone. core_dead suppresses the ack entirely.
  int   core_lat  = 5;
  bit   core_dead = 1'b0;
  bit   core_xor  = 1'b0;
  int   core_cnt;
  logic core_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_ack <= 1'b0;
      core_cnt <= 0;
    end else if (bus.eng_req && !core_ack && !core_dead) begin
      if (core_cnt == core_lat - 1) begin
        core_ack <= 1'b1;
        core_cnt <= 0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else if (!bus.eng_req) begin
      core_ack <= 1'b0;
      core_cnt <= 0;
    end
  end

  assign bus.eng_ack   = core_ack;
  assign bus.eng_rdata = core_xor ? (bus.eng_wdata ^ KEY) : KEY;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_gnt"},   32'(bus.cl_gnt),    32'h0);
    chk({p, "_req"},   32'(bus.eng_req),   32'h0);
    chk({p, "_wdata"}, bus.eng_wdata,      32'h0);
    chk({p, "_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({p, "_id"},    32'(bus.rsp_id),    32'h0);
    chk({p, "_data"},  bus.rsp_data,       32'h0);
    chk({p, "_err"},   32'(bus.rsp_err),   32'h0);
    chk({p, "_busy"},  32'(bus.busy),      32'h0);
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.cl_gnt != 0) begin
        g = bus.cl_gnt;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok, output int extra);
    ok    = 1'b0;
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cl_gnt != 0) extra++;
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic [31:0] data;
  } vec_t;

  vec_t        vt [10];
  logic [31:0] exp_data [4];
  int          exp_order [8];

  initial begin
    logic [3:0] g;
    bit         ok;
    int         extra;
    int         n;
    int         gq [$];
    int         nrsp;
    int         ngnt;
    logic [1:0] s_id;
    logic [31:0] s_data;
    bit         stable;

    // Expected core results with core_xor on: wdata ^ KEY, worked by hand.
    exp_data = '{32'h8f2668a8, 32'hbc155b9b, 32'had044a8a, 32'hda733dfd};
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    vt[0] = '{4'b1111, 4'b1000, 2'd3, 32'hda733dfd};
    vt[1] = '{4'b1111, 4'b0001, 2'd0, 32'h8f2668a8};
    vt[2] = '{4'b1111, 4'b0010, 2'd1, 32'hbc155b9b};
    vt[3] = '{4'b0101, 4'b0100, 2'd2, 32'had044a8a};
    vt[4] = '{4'b0101, 4'b0001, 2'd0, 32'h8f2668a8};
    vt[5] = '{4'b1010, 4'b0010, 2'd1, 32'hbc155b9b};
    vt[6] = '{4'b1000, 4'b1000, 2'd3, 32'hda733dfd};
    vt[7] = '{4'b0010, 4'b0010, 2'd1, 32'hbc155b9b};
    vt[8] = '{4'b0011, 4'b0001, 2'd0, 32'h8f2668a8};
    vt[9] = '{4'b1001, 4'b1000, 2'd3, 32'hda733dfd};

    bus.cl_req    = '0;
    bus.rsp_ready = 1'b0;
    bus.cl_wdata  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    // Single client 2, fixed core result, eng_req lasts 5 + SYNC + 1 cycles
    core_xor   = 1'b0;
    core_lat   = 5;
    bus.cl_wdata[64 +: 32] = 32'h41424344;
    bus.cl_req = 4'b0100;
    wait_gnt(g);
    bus.cl_req = '0;
    chk("t1_gnt", 32'(g), 32'h4);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    chk("t1_wdata", bus.eng_wdata, 32'h41424344);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.eng_req) n++;
      if (bus.rsp_valid) break;
    end
    chk("t1_req_cycles", 32'(n), 32'd8);
    chk("t1_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_id", 32'(bus.rsp_id), 32'd2);
    chk("t1_data", bus.rsp_data, 32'h9e3779b9);
    chk("t1_err", 32'(bus.rsp_err), 32'h0);
    ack_rsp();
    bus.cl_wdata[64 +: 32] = 32'h33333333;

    // Table of round-robin vectors
    core_xor = 1'b1;
    core_lat = 2;
    for (int v = 0; v < 10; v++) begin
      bus.cl_req = vt[v].req;
      wait_gnt(g);
      bus.cl_req = '0;
      chk($sformatf("vec%0d_gnt", v), 32'(g), 32'(vt[v].gnt));
      wait_rsp(ok, extra);
      chk($sformatf("vec%0d_rsp_seen", v), 32'(ok), 32'h1);
      chk($sformatf("vec%0d_extra_gnt", v), 32'(extra), 32'h0);
      chk($sformatf("vec%0d_id", v), 32'(bus.rsp_id), 32'(vt[v].id));
      chk($sformatf("vec%0d_data", v), bus.rsp_data, vt[v].data);
      chk($sformatf("vec%0d_err", v), 32'(bus.rsp_err), 32'h0);
      ack_rsp();
    end

    // All four requesting continuously for 8 words
    bus.rsp_ready = 1'b1;
    bus.cl_req    = 4'b1111;
    nrsp = 0;
    ngnt = 0;
    for (int i = 0; i < 600 && nrsp < 8; i++) begin
      @(negedge clk);
      if (bus.cl_gnt != 0) begin
        for (int b = 0; b < 4; b++) if (bus.cl_gnt[b]) gq.push_back(b);
        ngnt++;
        if (ngnt - nrsp > 1) chk("rr_double_gnt", 32'(ngnt - nrsp), 32'd1);
      end
      if (bus.rsp_valid) begin
        if (nrsp < 8) chk($sformatf("rr%0d_gnt_order", nrsp), 32'(gq[nrsp]), 32'(exp_order[nrsp]));
        chk($sformatf("rr%0d_id", nrsp), 32'(bus.rsp_id), 32'(gq[nrsp]));
        chk($sformatf("rr%0d_data", nrsp), bus.rsp_data, exp_data[gq[nrsp]]);
        nrsp++;
        if (nrsp == 8) bus.cl_req = '0;
      end
    end
    chk("rr_count", 32'(nrsp), 32'd8);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rr_idle", 32'(bus.busy), 32'h0);

    // Watchdog: core never acks
    core_dead  = 1'b1;
    bus.cl_req = 4'b0010;
    wait_gnt(g);
    bus.cl_req = '0;
    chk("wd_gnt", 32'(g), 32'h2);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.eng_req) n++;
      if (bus.rsp_valid) break;
    end
    chk("wd_req_cycles", 32'(n), 32'd16);
    chk("wd_valid", 32'(bus.rsp_valid), 32'h1);
    chk("wd_err", 32'(bus.rsp_err), 32'h1);
    chk("wd_data", bus.rsp_data, 32'h0);
    chk("wd_id", 32'(bus.rsp_id), 32'd1);
    ack_rsp();
    core_dead  = 1'b0;
    bus.cl_req = 4'b0010;
    wait_gnt(g);
    bus.cl_req = '0;
    wait_rsp(ok, extra);
    chk("wd_next_seen", 32'(ok), 32'h1);
    chk("wd_next_err", 32'(bus.rsp_err), 32'h0);
    chk("wd_next_data", bus.rsp_data, 32'hbc155b9b);
    ack_rsp();

    // Response stall: ready low for 20 cycles with other clients pending
    bus.cl_req = 4'b0100;
    wait_gnt(g);
    chk("st_gnt", 32'(g), 32'h4);
    bus.cl_req = 4'b1111;
    wait_rsp(ok, extra);
    chk("st_seen", 32'(ok), 32'h1);
    s_id   = bus.rsp_id;
    s_data = bus.rsp_data;
    chk("st_id", 32'(s_id), 32'd2);
    chk("st_data", s_data, 32'had044a8a);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_id != s_id || bus.rsp_data != s_data || bus.cl_gnt != 0)
        stable = 1'b0;
    end
    chk("st_stable", 32'(stable), 32'h1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("st_hs_valid", 32'(bus.rsp_valid), 32'h0);
    chk("st_hs_gnt", 32'(bus.cl_gnt), 32'h0);
    @(negedge clk);
    chk("st_next_gnt", 32'(bus.cl_gnt), 32'h8);
    bus.cl_req = '0;
    wait_rsp(ok, extra);
    ack_rsp();

    // Reset while in REQ with the core ack high
    core_lat   = 1;
    bus.cl_req = 4'b0100;
    wait_gnt(g);
    bus.cl_req = '0;
    @(negedge clk);
    chk("rm_pre_ack", 32'(bus.eng_ack), 32'h1);
    chk("rm_pre_req", 32'(bus.eng_req), 32'h1);
    #2 rst = 1'b1;
    #1 chk_reset("rm");
    @(negedge clk);
    rst        = 1'b0;
    bus.cl_req = 4'b1111;
    wait_gnt(g);
    bus.cl_req = '0;
    chk("rm_first_gnt", 32'(g), 32'h1);
    wait_rsp(ok, extra);
    chk("rm_rsp_id", 32'(bus.rsp_id), 32'd0);
    ack_rsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tea_arbiter.md
# tea_arbiter

Round-robin arbiter and sequencer that shares one TEA cipher core (the `tinyenc`/`tinydec` req/ack datapath) between N requesters. It grants one client at a time and latches that client's 32-bit word. It then runs a full four-phase req/ack exchange with the core, with the core's ack synchronised into the arbiter clock domain. The result is returned on a single valid/ready response channel tagged with the client ID. A watchdog aborts exchanges the core never acknowledges.

## Interface
- `N`, 4: number of requesting clients (2..16).
- `W`, 32: data word width; must match the core.
- `SYNC`, 2: flops in the ack synchroniser (≥2).
- `TIMEOUT`, 1024: max cycles waiting on each ack edge; 0 disables the watchdog.

- `clk` in 1: arbiter clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cl_req` in N: per-client request level.
- `cl_wdata` in N*W: client words, client i at bits [i*W +: W].
- `cl_gnt` out N: one-hot, one-cycle grant pulse.
- `eng_req` out 1: request to core.
- `eng_wdata` out W: latched word to core.
- `eng_ack` in 1: core ack, asynchronous to `clk`.
- `eng_rdata` in W: core result, stable while ack is high.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out clog2(N): client that owns the response.
- `rsp_data` out W: core result; all-zero on error.
- `rsp_err` out 1: watchdog abort flag.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, REQ, DROP, RSP.
- **IDLE**
  - If `|cl_req`, pick the first set bit searching from `last+1` upward, wrapping modulo N.
  - Register `cl_gnt[i]`=1 for exactly one cycle; latch `cl_wdata[i]` into `eng_wdata` and i into `rsp_id`; set `last`=i.
  - Assert `eng_req`, clear the watchdog, go to REQ.
- **REQ**
  - `eng_req`=1. When synchronised ack `ack_s`=1: capture `eng_rdata` into `rsp_data`, set `rsp_err`=0, drop `eng_req`, clear the watchdog, go to DROP.
  - On watchdog expiry: drop `eng_req`, set `rsp_err`=1, set `rsp_data`=0, go to DROP.
- **DROP**
  - `eng_req`=0. When `ack_s`=0, go to RSP.
  - Watchdog expiry here also goes to RSP with `rsp_err`=1.
- **RSP**
  - `rsp_valid`=1 and `rsp_id`, `rsp_data`, `rsp_err` held stable until `rsp_valid & rsp_ready`, then go to IDLE.
- Clients must hold `cl_req` and `cl_wdata` until they see their `cl_gnt`. A request still high after its grant counts as a new request in the next IDLE.
- Watchdog: counter of width clog2(TIMEOUT+1). It increments in REQ and DROP and expires when count == TIMEOUT-1. With `TIMEOUT`=0 the FSM waits indefinitely.
- Reset values (all outputs and state):
  - `cl_gnt`=0, `eng_req`=0, `eng_wdata`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0.
  - `last`=N-1, so client 0 has first priority.
  - Synchroniser flops=0, state=IDLE.
- Reset mid-exchange drops `eng_req` immediately; the core must be reset alongside.

## Timing
- `cl_req[i]` sampled high at edge t in IDLE → `cl_gnt[i]`, `eng_req` and `busy` high after edge t. `cl_gnt` low after edge t+1.
- `ack_s` follows `eng_ack` by `SYNC` clk edges.
- `eng_req` falls on the first edge at which `ack_s`=1 is seen.
- `rsp_valid` rises on the edge after `ack_s`=0 is seen in DROP.
- Handshake: `rsp_valid` & `rsp_ready` high at edge u → RSP→IDLE at u. The earliest next grant is at edge u+1.
- Minimum turnaround per word, with a zero-latency core: 2·SYNC+3 cycles.
- No request is ever granted while `busy`=1. Exactly one grant per response.

## Structure
- Package `tea_ctl_pkg`: state enum `tea_arb_state_t` {IDLE, REQ, DROP, RSP} and the default-parameter constants.
- One sub-module, `tea_sync`: parameterised `SYNC`-stage single-bit synchroniser with async active-high reset to 0, used for `eng_ack`.
- Round-robin pick is a combinational function in the package: rotate by `last+1`, find first one, add the offset back modulo N.

## Test plan
- Single client 2, `cl_wdata`=32'h41424344, core model acks after 5 cycles with rdata 32'h9e3779b9 → one `cl_gnt`=4'b0100 pulse; `rsp_valid` with `rsp_id`=2, `rsp_data`=32'h9e3779b9, `rsp_err`=0; `eng_req` high exactly until `ack_s` rises.
- All four `cl_req` held high continuously for 8 words → grant order 0,1,2,3,0,1,2,3. Each response ID matches its grant; never two grants per response.
- Core model never acks, `TIMEOUT`=16 → `eng_req` drops 16 cycles after rising; `rsp_err`=1, `rsp_data`=0; the next request is served normally.
- `rsp_ready` held low for 20 cycles in RSP → `rsp_valid`, `rsp_id`, `rsp_data` stable throughout; no new `cl_gnt` until the handshake completes.
- Assert `rst` while in REQ with `eng_ack` high → all outputs return to their reset values asynchronously. After release, client 0 wins when all clients request.
- Encrypt-then-decrypt loopback with real `tinyenc`/`tinydec` behind two arbiters, 1000 random printable words → every decrypted response equals its original word.
